spi_dep_master: RTL

- SPI master (mode 0: CPOL=0, CPHA=0) that drives the sobel/GCD SPI slave port from a host-side command stream, for use in FPGA test harnesses and on-chip self-test.
- Accepts 16-bit command words over a valid/ready handshake and shifts each one out as a single chip-select frame.
- Captures the slave's 16-bit reply from the same frame and returns it on a one-cycle response strobe.

---
 rtl/spi_dep_master.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/spi_dep_master.sv
// SPI mode-0 master: each accepted command is shifted out MSB first in its own CS frame; the reply from that frame is returned on a one-cycle strobe.
// Define SPI_DEP_MASTER_BURST_EN to chain commands that are pending at a word boundary into the same CS window.
module spi_dep_master #(
  parameter int WORD_SIZE    = 16,
  parameter int CLK_DIV      = 4,
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC  = 2,
  parameter int CS_GAP_CYC   = 4
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  input  logic [WORD_SIZE-1:0] cmd_data_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  output logic [WORD_SIZE-1:0] rsp_data_o,
  output logic                 rsp_valid_o,
  output logic                 busy_o,
  output logic                 spi_sck_o,
  output logic                 spi_cs_o,
  output logic                 spi_sdo_o,
  input  logic                 spi_sdi_i
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W   = $clog2(WORD_SIZE + 1);
  localparam int MAX_SH  = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int MAX_CYC = (MAX_SH > CS_GAP_CYC) ? MAX_SH : CS_GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD_SIZE);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP_CYC - 1);
`ifdef SPI_DEP_MASTER_BURST_EN
  localparam logic [DIV_W-1:0] DIV_PRE    = DIV_W'(CLK_DIV - 2);
`endif

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t               state;
  logic [DIV_W-1:0]     div;
  logic [BIT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     cnt;
  logic [WORD_SIZE-1:0] tx_sr;
  logic [WORD_SIZE-1:0] rx_sr;
  logic [WORD_SIZE-1:0] rx_next;
  logic                 sdi_meta;
  logic                 sdi_sync;

  // MISO is asynchronous to clk_i
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      sdi_meta <= 1'b0;
      sdi_sync <= 1'b0;
    end else begin
      sdi_meta <= spi_sdi_i;
      sdi_sync <= sdi_meta;
    end
  end

  assign rx_next = {rx_sr[WORD_SIZE-2:0], sdi_sync};

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state       <= IDLE;
      div         <= '0;
      bit_cnt     <= '0;
      cnt         <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      rsp_data_o  <= '0;
      rsp_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      cmd_ready_o <= 1'b1;
      spi_sck_o   <= 1'b0;
      spi_cs_o    <= 1'b1;
      spi_sdo_o   <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            tx_sr       <= cmd_data_i;
            spi_sdo_o   <= cmd_data_i[WORD_SIZE-1];
            spi_cs_o    <= 1'b0;
            busy_o      <= 1'b1;
            cmd_ready_o <= 1'b0;
            cnt         <= '0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt     <= '0;
            div     <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SHIFT: begin
          if (div == DIV_LAST) begin
            div       <= '0;
            spi_sck_o <= ~spi_sck_o;
            if (!spi_sck_o) begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end else begin
              // Falling edge: capture MISO at the end of the high phase, then advance MOSI
              rx_sr <= rx_next;
              if (bit_cnt < BIT_LAST) begin
                tx_sr     <= {tx_sr[WORD_SIZE-2:0], 1'b0};
                spi_sdo_o <= tx_sr[WORD_SIZE-2];
              end
`ifdef SPI_DEP_MASTER_BURST_EN
              else if (cmd_valid_i && cmd_ready_o) begin
                tx_sr       <= cmd_data_i;
                spi_sdo_o   <= cmd_data_i[WORD_SIZE-1];
                bit_cnt     <= '0;
                cmd_ready_o <= 1'b0;
                rsp_data_o  <= rx_next;
                rsp_valid_o <= 1'b1;
              end
`endif
              else begin
                cmd_ready_o <= 1'b0;
                cnt         <= '0;
                state       <= HOLD;
              end
            end
          end else begin
            div <= div + DIV_W'(1);
`ifdef SPI_DEP_MASTER_BURST_EN
            // Open the ready window for exactly the cycle of the last falling edge
            if (div == DIV_PRE && spi_sck_o && bit_cnt == BIT_LAST) begin
              cmd_ready_o <= 1'b1;
            end
`endif
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            spi_cs_o    <= 1'b1;
            spi_sdo_o   <= 1'b0;
            rsp_data_o  <= rx_sr;
            rsp_valid_o <= 1'b1;
            cnt         <= '0;
            state       <= GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            busy_o      <= 1'b0;
            cmd_ready_o <= 1'b1;
            cnt         <= '0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
